alu_arbiter: RTL and testbench

Sequencer and arbiter that shares one 2-bit ALU datapath between two requesters. The ALU has operands a[1:0], b[1:0], cin and select[1:0], and produces out[3:0]. Each requester submits an operation over a valid/ready channel. The block round-robins between requesters, drives the registered operands into the ALU, waits a fixed number of ALU cycles, captures the result, and returns it to the owner over a valid/ready response channel. One operation is in flight at a time. The ALU is instantiated beside this block, at the same level.

---
 rtl/alu_arbiter_if.sv | 23 ++
 rtl/alu_arbiter.sv | 101 ++++++++++
 tb/tb_alu_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// One requester's operation channel and result channel.
// The requester is the master; the arbiter is the slave.
interface alu_arbiter_if;
   logic       req_valid;
   logic [1:0] req_a;
   logic [1:0] req_b;
   logic       req_cin;
   logic [1:0] req_sel;
   logic       req_ready;
   logic       rsp_valid;
   logic [3:0] rsp_data;
   logic       rsp_ready;

   modport master (
      output req_valid, req_a, req_b, req_cin, req_sel, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_a, req_b, req_cin, req_sel, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sequencer that shares one external 2-bit ALU between two requesters.
// One operation is in flight at a time: accept, wait ALU_LAT cycles, return the result.
module alu_arbiter #(
   parameter int ALU_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave req0,
   alu_arbiter_if.slave req1,
   output logic [1:0]   alu_a,
   output logic [1:0]   alu_b,
   output logic         alu_cin,
   output logic [1:0]   alu_sel,
   input  logic [3:0]   alu_out,
   output logic         busy,
   output logic         grant_id
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [1:0] CNT_LOAD = 2'(ALU_LAT - 1);

   logic [1:0] state;
   logic       rr;
   logic [1:0] cnt;
   logic [3:0] result;
   logic       grant;
   logic       accept;
   logic       rsp_fire;

   // A lone requester wins outright; a tie goes to the round-robin pointer.
   always_comb begin
      grant = rr;
      if (req0.req_valid && !req1.req_valid) begin
         grant = 1'b0;
      end else if (req1.req_valid && !req0.req_valid) begin
         grant = 1'b1;
      end
   end

   assign req0.req_ready = rst_n && (state == IDLE) && req0.req_valid && !grant;
   assign req1.req_ready = rst_n && (state == IDLE) && req1.req_valid && grant;
   assign accept         = req0.req_ready || req1.req_ready;

   assign req0.rsp_valid = (state == RESP) && !grant_id;
   assign req1.rsp_valid = (state == RESP) && grant_id;
   assign req0.rsp_data  = result;
   assign req1.rsp_data  = result;
   assign rsp_fire       = (state == RESP) && (grant_id ? req1.rsp_ready : req0.rsp_ready);

   assign busy = (state != IDLE);

   // Operand registers feed the ALU directly and hold their values while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr       <= 1'b0;
         cnt      <= 2'd0;
         result   <= 4'd0;
         grant_id <= 1'b0;
         alu_a    <= 2'd0;
         alu_b    <= 2'd0;
         alu_cin  <= 1'b0;
         alu_sel  <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_a    <= grant ? req1.req_a   : req0.req_a;
                  alu_b    <= grant ? req1.req_b   : req0.req_b;
                  alu_cin  <= grant ? req1.req_cin : req0.req_cin;
                  alu_sel  <= grant ? req1.req_sel : req0.req_sel;
                  grant_id <= grant;
                  cnt      <= CNT_LOAD;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == 2'd0) begin
                  result <= alu_out;
                  state  <= RESP;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RESP: begin
               if (rsp_fire) begin
                  rr    <= ~grant_id;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_LAT=1 and one with ALU_LAT=3,
// each driving its own behavioural ALU.
module tb_alu_arbiter;

   logic clk = 1'b0;
   logic rst_n;

   alu_arbiter_if r0a ();
   alu_arbiter_if r1a ();
   alu_arbiter_if r0b ();
   alu_arbiter_if r1b ();

   logic [1:0] aa1, ab1, asel1, aa3, ab3, asel3;
   logic       acin1, acin3, busy1, busy3, gid1, gid3;
   logic [3:0] aout1, aout3;

   int checks;
   int errors;

   logic [12:0] st1, st3;
   logic        expg;
   logic [3:0]  expd;

   always #5 clk = ~clk;

   // Reference ALU: add with carry for select 00, bitwise ops otherwise.
   function automatic logic [3:0] aluModel(input logic [1:0] a, input logic [1:0] b,
                                           input logic cin, input logic [1:0] sel);
      case (sel)
         2'b00:   aluModel = {2'b00, a} + {2'b00, b} + {3'b000, cin};
         2'b01:   aluModel = {2'b00, a & b};
         2'b10:   aluModel = {2'b00, a | b};
         default: aluModel = {2'b00, a ^ b};
      endcase
   endfunction

   assign aout1 = aluModel(aa1, ab1, acin1, asel1);
   assign aout3 = aluModel(aa3, ab3, acin3, asel3);

   assign st1 = {busy1, gid1, aa1, ab1, acin1, asel1,
                 r0a.req_ready, r1a.req_ready, r0a.rsp_valid, r1a.rsp_valid};
   assign st3 = {busy3, gid3, aa3, ab3, acin3, asel3,
                 r0b.req_ready, r1b.req_ready, r0b.rsp_valid, r1b.rsp_valid};

   alu_arbiter #(.ALU_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req0(r0a), .req1(r1a),
      .alu_a(aa1), .alu_b(ab1), .alu_cin(acin1), .alu_sel(asel1),
      .alu_out(aout1), .busy(busy1), .grant_id(gid1)
   );

   alu_arbiter #(.ALU_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req0(r0b), .req1(r1b),
      .alu_a(aa3), .alu_b(ab3), .alu_cin(acin3), .alu_sel(asel3),
      .alu_out(aout3), .busy(busy3), .grant_id(gid3)
   );

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // dut 1 selects the ALU_LAT=1 instance, anything else the ALU_LAT=3 one.
   task automatic applyStimulus(input int dut, input int req, input logic v,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic cin, input logic [1:0] sel);
      if (dut == 1 && req == 0) begin
         r0a.req_valid = v; r0a.req_a = a; r0a.req_b = b; r0a.req_cin = cin; r0a.req_sel = sel;
      end else if (dut == 1) begin
         r1a.req_valid = v; r1a.req_a = a; r1a.req_b = b; r1a.req_cin = cin; r1a.req_sel = sel;
      end else if (req == 0) begin
         r0b.req_valid = v; r0b.req_a = a; r0b.req_b = b; r0b.req_cin = cin; r0b.req_sel = sel;
      end else begin
         r1b.req_valid = v; r1b.req_a = a; r1b.req_b = b; r1b.req_cin = cin; r1b.req_sel = sel;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      for (int d = 1; d <= 3; d += 2) begin
         applyStimulus(d, 0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
         applyStimulus(d, 1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
      end
      r0a.rsp_ready = 1'b1; r1a.rsp_ready = 1'b1;
      r0b.rsp_ready = 1'b1; r1b.rsp_ready = 1'b1;

      $display("[TB] reset and idle");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_state1", 16'(st1), 16'd0);
      checkOutput("rst_state3", 16'(st3), 16'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checkOutput("idle_state1", 16'(st1), 16'd0);
         checkOutput("idle_state3", 16'(st3), 16'd0);
      end

      $display("[TB] single op, latency 1");
      applyStimulus(1, 0, 1'b1, 2'd3, 2'd3, 1'b1, 2'b00);
      #1;
      checkOutput("single_ready", {r1a.req_ready, r0a.req_ready}, 16'b01);
      step();
      applyStimulus(1, 0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
      #1;
      checkOutput("single_exec", {busy1, gid1, aa1, ab1, acin1, asel1, r0a.rsp_valid},
                  {1'b1, 1'b0, 2'd3, 2'd3, 1'b1, 2'b00, 1'b0});
      step();
      checkOutput("single_rsp", {r1a.rsp_valid, r0a.rsp_valid, r0a.rsp_data}, {2'b01, 4'b0111});
      step();
      checkOutput("single_done", {busy1, r0a.rsp_valid, r1a.rsp_valid}, 16'd0);

      $display("[TB] simultaneous requests");
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      applyStimulus(1, 0, 1'b1, 2'd1, 2'd2, 1'b0, 2'b00);
      applyStimulus(1, 1, 1'b1, 2'd2, 2'd2, 1'b1, 2'b00);
      for (int k = 0; k < 4; k++) begin
         expg = 1'(k % 2);
         expd = expg ? 4'd5 : 4'd3;
         #1;
         checkOutput("rr_ready", {r1a.req_ready, r0a.req_ready}, expg ? 16'b10 : 16'b01);
         step();
         checkOutput("rr_grant", 16'(gid1), 16'(expg));
         step();
         checkOutput("rr_rsp", expg ? {r1a.rsp_valid, r1a.rsp_data} : {r0a.rsp_valid, r0a.rsp_data},
                     {1'b1, expd});
         step();
      end
      applyStimulus(1, 0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
      applyStimulus(1, 1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);

      $display("[TB] response backpressure");
      r1a.rsp_ready = 1'b0;
      applyStimulus(1, 1, 1'b1, 2'd1, 2'd1, 1'b0, 2'b01);
      #1;
      checkOutput("bp_accept1", 16'(r1a.req_ready), 16'd1);
      step();
      applyStimulus(1, 1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
      applyStimulus(1, 0, 1'b1, 2'd2, 2'd1, 1'b1, 2'b10);
      step();
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_stall", {r1a.rsp_valid, r1a.rsp_data, r0a.req_ready}, {1'b1, 4'd1, 1'b0});
         step();
      end
      r1a.rsp_ready = 1'b1;
      #1;
      checkOutput("bp_release", {r1a.rsp_valid, r0a.req_ready}, 16'b10);
      step();
      checkOutput("bp_next_ready", {busy1, r0a.req_ready}, 16'b01);
      step();
      applyStimulus(1, 0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
      checkOutput("bp_next_exec", {gid1, asel1}, {1'b0, 2'b10});
      step();
      checkOutput("bp_next_rsp", {r0a.rsp_valid, r0a.rsp_data}, {1'b1, 4'd3});
      step();

      $display("[TB] latency 3");
      applyStimulus(3, 0, 1'b1, 2'd2, 2'd3, 1'b0, 2'b11);
      #1;
      checkOutput("lat3_ready", 16'(r0b.req_ready), 16'd1);
      step();
      applyStimulus(3, 0, 1'b1, 2'd1, 2'd0, 1'b1, 2'b00);
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("lat3_exec", {aa3, ab3, acin3, asel3, r0b.rsp_valid, r0b.req_ready},
                     {2'd2, 2'd3, 1'b0, 2'b11, 1'b0, 1'b0});
         step();
      end
      checkOutput("lat3_rsp", {r0b.rsp_valid, r0b.rsp_data}, {1'b1, 4'd1});
      applyStimulus(3, 0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
      step();
      checkOutput("lat3_done", 16'(busy3), 16'd0);

      $display("[TB] reset mid-operation");
      applyStimulus(3, 1, 1'b1, 2'd1, 2'd1, 1'b1, 2'b00);
      step();
      applyStimulus(3, 1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
      checkOutput("abort_busy", {busy3, gid3}, 16'b11);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_cleared", 16'(st3), 16'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("abort_no_rsp", 16'(st3), 16'd0);
      end
      applyStimulus(3, 1, 1'b1, 2'd3, 2'd2, 1'b0, 2'b00);
      #1;
      checkOutput("after_ready", {r1b.req_ready, r0b.req_ready}, 16'b10);
      step();
      applyStimulus(3, 1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0);
      repeat (3) step();
      checkOutput("after_rsp", {r1b.rsp_valid, r0b.rsp_valid, r1b.rsp_data}, {2'b10, 4'd5});
      step();
      checkOutput("after_idle", 16'(busy3), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
